// File: rtl/diff_clk_fwd_obuf_pkg.sv
// Shared types and sizing helpers for the forwarded-clock blocks (tx and rx side).
package diff_clk_pkg;

  typedef enum logic [1:0] {IDLE, RUN, STOP} fwd_state_t;

  // Cycles per half period; DIV=1 has no half-period counter, treat as 1.
  function automatic int fwd_half(input int div);
    return (div < 2) ? 1 : div / 2;
  endfunction

  // ph_cnt width: $clog2(HALF), never below 1 bit.
  function automatic int fwd_ph_w(input int div);
    return (fwd_half(div) < 2) ? 1 : $clog2(fwd_half(div));
  endfunction

endpackage

// File: rtl/diff_clk_fwd_obuf_if.sv
// Control/status and differential pins of the forwarded-clock transmitter.
interface diff_clk_fwd_obuf_if #(parameter int LEN_W = 16);
  logic             start;
  logic             stop;
  logic [LEN_W-1:0] burst_len;
  logic             busy;
  logic             done;
  logic [LEN_W-1:0] cyc_cnt;
  logic             clk_out_p;
  logic             clk_out_n;

  modport master (output start, stop, burst_len,
                  input  busy, done, cyc_cnt, clk_out_p, clk_out_n);
  modport slave  (input  start, stop, burst_len,
                  output busy, done, cyc_cnt, clk_out_p, clk_out_n);
endinterface

// File: rtl/diff_clk_fwd_obuf_div.sv
// Half-period counter for the forwarded clock. The first enabled cycle launches
// the high phase immediately; dropping en parks phase low. boundary marks the
// cycle whose edge takes phase 1->0 (every cycle while high for DIV=1).
module clk_fwd_div
  import diff_clk_pkg::*;
#(
  parameter int DIV = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  output logic phase,
  output logic boundary
);

  localparam int HALF = fwd_half(DIV);
  localparam int PH_W = fwd_ph_w(DIV);

  logic [PH_W-1:0] ph_cnt;
  logic            run_q;
  logic            last;

  assign last     = (ph_cnt == PH_W'(HALF - 1));
  assign boundary = (DIV == 1) ? phase : (phase && last);

  // Phase generator: launch high, then toggle every HALF cycles while enabled.
  always_ff @(posedge clk) begin
    if (rst || !en) begin
      phase  <= 1'b0;
      ph_cnt <= '0;
      run_q  <= 1'b0;
    end else if (!run_q) begin
      run_q  <= 1'b1;
      phase  <= 1'b1;
      ph_cnt <= '0;
    end else if (DIV > 1) begin
      if (last) begin
        phase  <= ~phase;
        ph_cnt <= '0;
      end else begin
        ph_cnt <= ph_cnt + PH_W'(1);
      end
    end
  end

endmodule

// File: rtl/diff_clk_fwd_obuf.sv
// Forwarded clock transmitter: clk/DIV burst or continuous clock driven off-chip
// as a differential pair, starting and stopping only on whole periods.
// Build option DIFF_CLK_FWD_ODDR_EN: output register becomes an ODDR (enables DIV=1).
module diff_clk_fwd_obuf
  import diff_clk_pkg::*;
#(
  parameter int DIV   = 2,
  parameter int LEN_W = 16
) (
  input  logic                clk,
  input  logic                rst,
  diff_clk_fwd_obuf_if.slave  bus
);

  fwd_state_t       state, state_nx;
  logic [LEN_W-1:0] remaining;
  logic [LEN_W-1:0] cyc_cnt_q;
  logic             cont;
  logic             done_q;
  logic             phase, boundary;
  logic             busy, start_acc, fin_burst, end_now, en;
  logic             out_q;

  assign busy      = (state != IDLE);
  assign start_acc = !busy && bus.start;
  assign fin_burst = !cont && (remaining == LEN_W'(1));
  // A stop seen on a boundary cycle ends the run at that boundary (pulse already complete).
  assign end_now   = busy && boundary && ((state == STOP) || bus.stop || fin_burst);
  assign en        = start_acc || (busy && !end_now);

  clk_fwd_div #(.DIV(DIV)) u_div (
    .clk      (clk),
    .rst      (rst),
    .en       (en),
    .phase    (phase),
    .boundary (boundary)
  );

  // Next-state logic.
  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE:    if (bus.start) state_nx = RUN;
      RUN:     if (end_now) state_nx = IDLE; else if (bus.stop) state_nx = STOP;
      STOP:    if (end_now) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  // Burst bookkeeping, period counter and registered done strobe.
  always_ff @(posedge clk) begin
    if (rst) begin
      remaining <= '0;
      cont      <= 1'b0;
      cyc_cnt_q <= '0;
      done_q    <= 1'b0;
    end else begin
      done_q <= end_now;
      if (start_acc) begin
        remaining <= bus.burst_len;
        cont      <= (bus.burst_len == '0);
        cyc_cnt_q <= '0;
      end else if (busy && boundary) begin
        cyc_cnt_q <= cyc_cnt_q + LEN_W'(1);
        if (!cont) remaining <= remaining - LEN_W'(1);
      end
    end
  end

  if (DIV < 1 || (DIV > 1 && (DIV % 2) != 0)) begin : g_div_bad
    $error("diff_clk_fwd_obuf: DIV must be even and >= 2 (or 1 with ODDR)");
  end

`ifdef DIFF_CLK_FWD_ODDR_EN
  // ODDR, SAME_EDGE: D1 drives the clk-high half, D2 the clk-low half.
  logic d1, d2, d1_q, d2_q;
  assign d1 = phase;
  assign d2 = (DIV == 1) ? 1'b0 : phase;

  // ODDR data capture with synchronous R.
  always_ff @(posedge clk) begin
    if (rst) begin
      d1_q <= 1'b0;
      d2_q <= 1'b0;
    end else begin
      d1_q <= d1;
      d2_q <= d2;
    end
  end

  assign out_q = clk ? d1_q : d2_q;
`else
  if (DIV == 1) begin : g_div1_bad
    $error("diff_clk_fwd_obuf: DIV=1 requires DIFF_CLK_FWD_ODDR_EN");
  end

  // Plain output flop of phase.
  always_ff @(posedge clk) begin
    if (rst) out_q <= 1'b0;
    else     out_q <= phase;
  end
`endif

  // OBUFDS stand-in: O follows the register, OB its complement.
  assign bus.clk_out_p = out_q;
  assign bus.clk_out_n = ~out_q;

  assign bus.busy    = busy;
  assign bus.done    = done_q;
  assign bus.cyc_cnt = cyc_cnt_q;

endmodule

// File: tb/tb_diff_clk_fwd_obuf.sv
// Scoreboard bench for diff_clk_fwd_obuf (DIV=4; plus a DIV=1 instance in the ODDR build).
module tb_diff_clk_fwd_obuf;
  localparam int DIV   = 4;
  localparam int HALF  = DIV / 2;
  localparam int LEN_W = 16;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  diff_clk_fwd_obuf_if #(.LEN_W(LEN_W)) bus ();
  diff_clk_fwd_obuf #(.DIV(DIV), .LEN_W(LEN_W)) dut (.clk(clk), .rst(rst), .bus(bus));

`ifdef DIFF_CLK_FWD_ODDR_EN
  diff_clk_fwd_obuf_if #(.LEN_W(LEN_W)) bus1 ();
  diff_clk_fwd_obuf #(.DIV(1), .LEN_W(LEN_W)) dut1 (.clk(clk), .rst(rst), .bus(bus1));
  int pulses1 = 0;
  always @(posedge bus1.clk_out_p) pulses1++;
`endif

  typedef struct { int done_cyc; int cnt; } exp_t;
  exp_t q[$];

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  int pulses = 0;
  int base   = 0;
  int hi_run = 0;

  always @(posedge clk) cyc <= cyc + 1;
  always @(posedge bus.clk_out_p) pulses++;

  task automatic chk(input string nm, input longint act, input longint exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Reference: period k ends (phase 1->0) at T+(k-1)*DIV+HALF; a run ends at the
  // first boundary at or after the stop cycle, or after n periods, whichever first.
  function automatic int model_periods(input int n, input int soff);
    int k = 1;
    if (soff == 0) return n;
    while ((k - 1) * DIV + HALF < soff) k++;
    if (n != 0 && n < k) return n;
    return k;
  endfunction

  // Monitor: pops expectations on done, checks pulse widths.
  always @(negedge clk) begin
    if (rst) begin
      hi_run = 0;
      base   = pulses;
    end else begin
      if (bus.clk_out_p === 1'b1) hi_run++;
      else if (hi_run != 0) begin
        chk("high_width", hi_run, HALF);
        hi_run = 0;
      end
      if (bus.done === 1'b1) begin
        if (q.size() == 0) chk("done_unexpected", q.size(), 1);
        else begin
          exp_t e;
          e = q.pop_front();
          chk("done_cycle", cyc, e.done_cyc);
          chk("cyc_cnt_at_done", bus.cyc_cnt, e.cnt);
          chk("pulse_count", pulses - base, e.cnt);
          chk("busy_at_done", bus.busy, 0);
          base = pulses;
        end
      end
    end
  end

  // Differential legs must always be complementary.
  always @(clk) begin
    #1;
    if (!rst) begin
      chk("diff_pair", bus.clk_out_n, !bus.clk_out_p);
`ifdef DIFF_CLK_FWD_ODDR_EN
      chk("diff_pair1", bus1.clk_out_n, !bus1.clk_out_p);
`endif
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic run(input int n, input int soff, input bit inject);
    exp_t e;
    int   t;
    int   k;
    step();
    t = cyc;
    bus.start     = 1'b1;
    bus.burst_len = LEN_W'(n);
    k = model_periods(n, soff);
    e.done_cyc = t + (k - 1) * DIV + HALF + 1;
    e.cnt      = k;
    q.push_back(e);
    step();
    bus.start     = 1'b0;
    bus.burst_len = LEN_W'($urandom);
    chk("busy_after_start", bus.busy, 1);
    chk("out_low_t1", bus.clk_out_p, 0);
    while (cyc < e.done_cyc + 2) begin
      bus.stop  = (soff != 0 && cyc == t + soff);
      bus.start = inject && (cyc == t + 2);
      if (cyc == t + 2) chk("out_high_t2", bus.clk_out_p, 1);
      step();
    end
    bus.stop  = 1'b0;
    bus.start = 1'b0;
    chk("cnt_hold", bus.cyc_cnt, k);
    chk("idle_busy", bus.busy, 0);
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: no finish by cycle %0d", cyc);
    $fatal(1, "timeout");
  end

  initial begin
    int t;
    bus.start = 1'b0; bus.stop = 1'b0; bus.burst_len = '0;
`ifdef DIFF_CLK_FWD_ODDR_EN
    bus1.start = 1'b0; bus1.stop = 1'b0; bus1.burst_len = '0;
`endif
    rst = 1'b1;
    step();
    chk("rst_out_p", bus.clk_out_p, 0);
    chk("rst_out_n", bus.clk_out_n, 1);
    chk("rst_busy", bus.busy, 0);
    chk("rst_done", bus.done, 0);
    chk("rst_cnt", bus.cyc_cnt, 0);
    rst = 1'b0;
    step();

    run(3, 0, 1'b0);    // burst of 3
    run(0, 41, 1'b0);   // continuous, stop mid-high of period 11
    run(2, 6, 1'b0);    // stop on final boundary
    run(4, 0, 1'b1);    // start while busy ignored

    // stop while idle is ignored
    bus.stop = 1'b1;
    step();
    bus.stop = 1'b0;
    chk("idle_stop_busy", bus.busy, 0);
    step();
    chk("idle_stop_cnt", bus.cyc_cnt, 4);
    chk("idle_stop_busy2", bus.busy, 0);

    // reset mid-high of period 3 of a continuous run
    step();
    t = cyc;
    bus.start = 1'b1; bus.burst_len = '0;
    step();
    bus.start = 1'b0;
    while (cyc < t + 10) step();
    chk("pre_rst_high", bus.clk_out_p, 1);
    chk("pre_rst_cnt", bus.cyc_cnt, 2);
    rst = 1'b1;
    step();
    chk("mid_rst_out", bus.clk_out_p, 0);
    chk("mid_rst_busy", bus.busy, 0);
    chk("mid_rst_cnt", bus.cyc_cnt, 0);
    chk("mid_rst_done", bus.done, 0);
    step();
    rst = 1'b0;
    step();
    chk("post_rst_done", bus.done, 0);

    // randomized runs
    for (int i = 0; i < 16; i++) begin
      int n, soff;
      n = $urandom_range(0, 5);
      if (n == 0) soff = $urandom_range(1, 30);
      else if ($urandom_range(0, 1) == 1) soff = $urandom_range(1, n * DIV + 2);
      else soff = 0;
      run(n, soff, 1'($urandom_range(0, 1)));
    end

`ifdef DIFF_CLK_FWD_ODDR_EN
    begin
      int p0, dcyc;
      step();
      t = cyc;
      p0 = pulses1;
      dcyc = -1;
      bus1.start = 1'b1; bus1.burst_len = LEN_W'(5);
      step();
      bus1.start = 1'b0;
      while (cyc < t + 9) begin
        if (bus1.done === 1'b1 && dcyc < 0) dcyc = cyc;
        step();
      end
      chk("oddr_done_cyc", dcyc, t + 6);
      chk("oddr_pulses", pulses1 - p0, 5);
      chk("oddr_cnt", bus1.cyc_cnt, 5);
      chk("oddr_busy", bus1.busy, 0);
    end
`endif

    repeat (6) step();
    chk("pending_done", q.size(), 0);
    chk("stray_pulses", pulses - base, 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
